// File: rtl/ex_issue_stage.sv
// Two-stage execute issue: S1 decodes and registers ALU operands, holding mul/div ops for a
// fixed count; S2 captures the external ALU result under a valid/ready handshake.
module ex_issue_stage #(
   parameter int unsigned MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  alu_op,
   input  logic [2:0]  funct3,
   input  logic        funct7_30,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   input  logic [63:0] imm,
   input  logic        alu_src,
   input  logic [4:0]  rd,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [3:0]  alu_sel,
   input  logic [63:0] alu_out,
   input  logic        alu_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic        out_zero,
   output logic [4:0]  out_rd,
   output logic        out_divz,
   output logic        out_illegal
);

   localparam logic [3:0] SelAdd  = 4'b0000;
   localparam logic [3:0] SelSub  = 4'b0001;
   localparam logic [3:0] SelMul  = 4'b0010;
   localparam logic [3:0] SelDiv  = 4'b0011;
   localparam logic [3:0] SelSll  = 4'b0100;
   localparam logic [3:0] SelSrl  = 4'b0101;
   localparam logic [3:0] SelAnd  = 4'b1000;
   localparam logic [3:0] SelOr   = 4'b1001;
   localparam logic [3:0] SelXor  = 4'b1010;
   localparam logic [3:0] SelSlt  = 4'b1110;
   localparam logic [3:0] SelSltu = 4'b1111;
   localparam logic [3:0] HoldLoad = 4'(MULDIV_CYCLES - 1);

   logic [3:0]  dec_sel;
   logic        dec_illegal;
   logic [63:0] operand_b;
   logic        accept;
   logic        s1_advance;

   logic        s1_valid_q;
   logic [3:0]  hold_cnt_q;
   logic [63:0] alu_a_q, alu_b_q;
   logic [3:0]  alu_sel_q;
   logic [4:0]  s1_rd_q;
   logic        s1_illegal_q, s1_divz_q;
   logic        out_valid_q, out_zero_q, out_divz_q, out_illegal_q;
   logic [63:0] out_result_q;
   logic [4:0]  out_rd_q;

   always_comb begin
      dec_sel     = SelAdd;
      dec_illegal = 1'b0;
      unique case (alu_op)
         2'b00: dec_sel = SelAdd;
         2'b01: dec_sel = SelSub;
         2'b10: begin
            case (funct3)
               3'b000:  dec_sel = funct7_30 ? SelSub : SelAdd;
               3'b111:  dec_sel = SelAnd;
               3'b110:  dec_sel = SelOr;
               3'b100:  dec_sel = SelXor;
               3'b001:  dec_sel = SelSll;
               3'b101:  dec_sel = SelSrl;
               3'b010:  dec_sel = SelSlt;
               default: dec_sel = SelSltu;
            endcase
         end
         2'b11: begin
            case (funct3)
               3'b000:  dec_sel = SelMul;
               3'b100:  dec_sel = SelDiv;
               default: dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   assign operand_b  = alu_src ? imm : rs2_data;
   assign s1_advance = s1_valid_q && (hold_cnt_q == 4'd0) && (!out_valid_q || out_ready);
   assign in_ready   = !s1_valid_q || s1_advance;
   assign accept     = in_valid && in_ready;

   // A new op may enter S1 in the same cycle the previous one advances to S2.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         hold_cnt_q   <= 4'd0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= SelAdd;
         s1_rd_q      <= '0;
         s1_illegal_q <= 1'b0;
         s1_divz_q    <= 1'b0;
      end else if (accept) begin
         s1_valid_q   <= 1'b1;
         alu_a_q      <= rs1_data;
         alu_b_q      <= operand_b;
         alu_sel_q    <= dec_sel;
         s1_rd_q      <= rd;
         s1_illegal_q <= dec_illegal;
         s1_divz_q    <= (dec_sel == SelDiv) && (operand_b == 64'd0);
         hold_cnt_q   <= ((dec_sel == SelMul) || (dec_sel == SelDiv)) ? HoldLoad : 4'd0;
      end else begin
         if (s1_advance) s1_valid_q <= 1'b0;
         if (hold_cnt_q != 4'd0) hold_cnt_q <= hold_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_zero_q    <= 1'b0;
         out_rd_q      <= '0;
         out_divz_q    <= 1'b0;
         out_illegal_q <= 1'b0;
      end else if (s1_advance) begin
         out_valid_q   <= 1'b1;
         // Divide by zero ignores whatever the ALU produced.
         out_result_q  <= s1_divz_q ? '1 : alu_out;
         out_zero_q    <= s1_divz_q ? 1'b0 : alu_z;
         out_rd_q      <= s1_rd_q;
         out_divz_q    <= s1_divz_q;
         out_illegal_q <= s1_illegal_q;
      end else if (out_ready) begin
         out_valid_q   <= 1'b0;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_zero    = out_zero_q;
   assign out_rd      = out_rd_q;
   assign out_divz    = out_divz_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: behavioural ALU, instruction-level result model with an in-order
// scoreboard, directed scenarios followed by randomized traffic with random backpressure.
module tb_ex_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic        funct7_30;
   logic [63:0] rs1_data, rs2_data, imm;
   logic        alu_src;
   logic [4:0]  rd;
   logic [63:0] alu_a, alu_b;
   logic [3:0]  alu_sel;
   logic [63:0] alu_out;
   logic        alu_z;
   logic        out_valid, out_ready;
   logic [63:0] out_result;
   logic        out_zero;
   logic [4:0]  out_rd;
   logic        out_divz, out_illegal;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] res;
      logic        zero;
      logic [4:0]  rd;
      logic        divz;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];

   ex_issue_stage #(.MULDIV_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
      .funct3(funct3), .funct7_30(funct7_30), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .imm(imm), .alu_src(alu_src), .rd(rd), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_z(alu_z), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd), .out_divz(out_divz),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // Stand-in for the external ALU.
   always_comb begin
      alu_out = '0;
      case (alu_sel)
         4'b0000: alu_out = alu_a + alu_b;
         4'b0001: alu_out = alu_a - alu_b;
         4'b0010: alu_out = alu_a * alu_b;
         4'b0011: alu_out = (alu_b == 0) ? 64'd0 : alu_a / alu_b;
         4'b0100: alu_out = alu_a << alu_b[5:0];
         4'b0101: alu_out = alu_a >> alu_b[5:0];
         4'b1000: alu_out = alu_a & alu_b;
         4'b1001: alu_out = alu_a | alu_b;
         4'b1010: alu_out = alu_a ^ alu_b;
         4'b1110: alu_out = {63'd0, $signed(alu_a) < $signed(alu_b)};
         4'b1111: alu_out = {63'd0, alu_a < alu_b};
         default: alu_out = '0;
      endcase
   end
   assign alu_z = (alu_out == 64'd0);

   // Instruction-level expected outcome.
   function automatic exp_t ref_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [4:0] rdv);
      exp_t e;
      e = '0;
      e.rd = rdv;
      case (op)
         2'd0: e.res = a + b;
         2'd1: e.res = a - b;
         2'd2: begin
            case (f3)
               3'd0: e.res = f7 ? a - b : a + b;
               3'd7: e.res = a & b;
               3'd6: e.res = a | b;
               3'd4: e.res = a ^ b;
               3'd1: e.res = a << b[5:0];
               3'd5: e.res = a >> b[5:0];
               3'd2: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
               default: e.res = (a < b) ? 64'd1 : 64'd0;
            endcase
         end
         default: begin
            if (f3 == 3'd0) e.res = a * b;
            else if (f3 == 3'd4) begin
               if (b == 0) begin
                  e.divz = 1'b1;
                  e.res  = '1;
               end else e.res = a / b;
            end else begin
               e.ill = 1'b1;
               e.res = a + b;
            end
         end
      endcase
      e.zero = !e.divz && (e.res == 64'd0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every accepted op must leave exactly once, in order.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_output", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_result", out_result, e.res);
               check("sb_zero", 64'(out_zero), 64'(e.zero));
               check("sb_rd", 64'(out_rd), 64'(e.rd));
               check("sb_divz", 64'(out_divz), 64'(e.divz));
               check("sb_illegal", 64'(out_illegal), 64'(e.ill));
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(ref_op(alu_op, funct3, funct7_30, rs1_data,
                                   alu_src ? imm : rs2_data, rd));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                        input logic src, input logic [4:0] rdv);
      in_valid  = 1'b1;
      alu_op    = op;
      funct3    = f3;
      funct7_30 = f7;
      rs1_data  = a;
      rs2_data  = b;
      imm       = im;
      alu_src   = src;
      rd        = rdv;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      alu_op = '0; funct3 = '0; funct7_30 = 1'b0;
      rs1_data = '0; rs2_data = '0; imm = '0; alu_src = 1'b0; rd = '0;
      step();
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_alu_a", alu_a, 64'd0);
      check("rst_alu_b", alu_b, 64'd0);
      check("rst_alu_sel", 64'(alu_sel), 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_flags", {out_zero, out_divz, out_illegal}, 64'd0);
      check("rst_out_rd", 64'(out_rd), 64'd0);
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // R-type sub giving zero
      drive(2'b10, 3'b000, 1'b1, 64'd10, 64'd10, 64'd0, 1'b0, 5'd3);
      step();
      in_valid = 1'b0;
      check("sub_alu_sel", 64'(alu_sel), 64'b0001);
      step();
      check("sub_out_valid", 64'(out_valid), 64'd1);
      check("sub_result", out_result, 64'd0);
      check("sub_zero", 64'(out_zero), 64'd1);

      // I-type add with negative immediate
      drive(2'b00, 3'b000, 1'b0, 64'd5, 64'd99, -64'sd3, 1'b1, 5'd4);
      step();
      in_valid = 1'b0;
      check("addi_alu_b", alu_b, -64'sd3);
      step();
      check("addi_result", out_result, 64'd2);
      check("addi_zero", 64'(out_zero), 64'd0);

      // Divide by zero: held three cycles, result at N+5
      drive(2'b11, 3'b100, 1'b0, 64'd7, 64'd0, 64'd0, 1'b0, 5'd5);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("div_in_ready_held", 64'(in_ready), 64'd0);
         if (i < 2) step();
      end
      step();
      check("div_in_ready_release", 64'(in_ready), 64'd1);
      check("div_not_early", 64'(out_valid), 64'd0);
      step();
      check("div_out_valid", 64'(out_valid), 64'd1);
      check("div_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
      check("div_divz", 64'(out_divz), 64'd1);
      check("div_zero", 64'(out_zero), 64'd0);
      step();

      // Backpressure with three back-to-back adds
      out_ready = 1'b0;
      drive(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0, 1'b0, 5'd6);
      step();
      check("bp_in_ready_1", 64'(in_ready), 64'd1);
      drive(2'b00, 3'b000, 1'b0, 64'd10, 64'd20, 64'd0, 1'b0, 5'd7);
      step();
      check("bp_in_ready_fall", 64'(in_ready), 64'd0);
      drive(2'b00, 3'b000, 1'b0, 64'd100, 64'd200, 64'd0, 1'b0, 5'd8);
      for (int i = 0; i < 2; i++) begin
         step();
         check("bp_stall_ready", 64'(in_ready), 64'd0);
         check("bp_hold_result", out_result, 64'd3);
      end
      out_ready = 1'b1;
      check("bp_first_valid", 64'(out_valid), 64'd1);
      step();
      in_valid = 1'b0;
      check("bp_second", out_result, 64'd30);
      step();
      check("bp_third", out_result, 64'd300);
      check("bp_third_rd", 64'(out_rd), 64'd8);
      step();
      check("bp_drained", 64'(out_valid), 64'd0);

      // Illegal mul/div funct3
      drive(2'b11, 3'b011, 1'b0, 64'd4, 64'd6, 64'd0, 1'b0, 5'd9);
      step();
      in_valid = 1'b0;
      check("ill_alu_sel", 64'(alu_sel), 64'd0);
      step();
      check("ill_flag", 64'(out_illegal), 64'd1);

      // Reset during a multiply hold
      drive(2'b11, 3'b000, 1'b0, 64'd3, 64'd4, 64'd0, 1'b0, 5'd10);
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         check("rst_mid_no_output", 64'(out_valid), 64'd0);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         alu_op    = 2'($urandom_range(3));
         funct3    = 3'($urandom_range(7));
         funct7_30 = 1'($urandom_range(1));
         rs1_data  = ($urandom_range(3) == 0) ? 64'($urandom_range(15)) : {$urandom, $urandom};
         rs2_data  = ($urandom_range(3) == 0) ? 64'($urandom_range(3)) : {$urandom, $urandom};
         imm       = ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom};
         alu_src   = 1'($urandom_range(1));
         rd        = 5'($urandom_range(31));
         out_ready = ($urandom_range(3) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
      step();
      check("drain_all_delivered", 64'(exp_q.size()), 64'd0);
      check("drain_idle", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
